// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and width helpers for the FIFO write arbiter and
//             its round-robin picker.
//  Contents : arb_state_t - arbiter FSM state encoding (IDLE, GRANT)
//             occ_width() - bits needed to count 0..depth entries
//             idx_width() - bits needed to index n requesters (min 1)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Occupancy must represent the full value DEPTH, hence depth+1 codes.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Keep at least one bit so a single-requester build still has a port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin priority picker. Returns the first
//             asserted request found searching upward from rr_ptr, wrapping
//             at NUM_REQ.
//  Ports    : req       in  NUM_REQ  request vector
//             rr_ptr    in  IDX_W    highest-priority position (< NUM_REQ)
//             winner    out IDX_W    index of selected request (0 if none)
//             any_valid out 1        at least one request asserted
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // Scan offsets from the far end toward rr_ptr so the nearest hit is the
    // last one written and therefore wins.
    always_comb begin : p_pick
        int               w_idx;
        logic [IDX_W-1:0] w_sel;
        w_idx     = 0;
        w_sel     = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = int'(rr_ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = IDX_W'(w_idx);
            if (req[w_sel]) begin
                winner    = w_sel;
                any_valid = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Shares one synchronous FIFO write port among NUM_REQ producers
//             with round-robin grants of at most MAX_BURST beats. Tracks FIFO
//             occupancy itself so the FIFO is never written when full.
//  Ports    : clk, reset   clock, synchronous active-high reset
//             req_valid    in  per-requester valid
//             req_data     in  requester i at [i*WIDTH +: WIDTH]
//             req_ready    out per-requester accept (combinational)
//             fifo_wren    out registered FIFO write enable
//             fifo_wrdata  out registered FIFO write data
//             fifo_rd_done in  consumer read accepted by the FIFO
//             occupancy    out entries written or reserved, not yet read
//             grant_id     out current owner, valid while busy
//             busy         out FSM in GRANT
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           fifo_wren,
    output logic [WIDTH-1:0]               fifo_wrdata,
    input  logic                           fifo_rd_done,
    output logic [occ_width(DEPTH)-1:0]    occupancy,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id,
    output logic                           busy
);

    localparam int                   c_OCC_W     = occ_width(DEPTH);
    localparam int                   c_IDX_W     = idx_width(NUM_REQ);
    localparam logic [c_OCC_W-1:0]   c_DEPTH     = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0]   c_OCC_ONE   = c_OCC_W'(1);
    localparam logic [7:0]           c_MAX_BURST = 8'(MAX_BURST);
    localparam logic [c_IDX_W-1:0]   c_LAST_ID   = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE   = c_IDX_W'(1);

    arb_state_t           r_state,       w_state_nxt;
    logic [c_IDX_W-1:0]   r_grant_id,    w_grant_id_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr,      w_rr_ptr_nxt;
    logic [7:0]           r_beat_cnt,    w_beat_cnt_nxt;
    logic [c_OCC_W-1:0]   r_occupancy,   w_occupancy_nxt;
    logic                 r_fifo_wren,   w_fifo_wren_nxt;
    logic [WIDTH-1:0]     r_fifo_wrdata, w_fifo_wrdata_nxt;

    logic [c_IDX_W-1:0]   w_pick_id;
    logic                 w_pick_any;
    logic                 w_space;
    logic                 w_owner_valid;
    logic                 w_handshake;
    logic                 w_rd_dec;
    logic [c_IDX_W-1:0]   w_rr_after_owner;
    logic [WIDTH-1:0]     w_lane [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lanes
            assign w_lane[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .req       (req_valid),
        .rr_ptr    (r_rr_ptr),
        .winner    (w_pick_id),
        .any_valid (w_pick_any)
    );

    // Ready depends only on registered state, so a read strobe in a full
    // cycle cannot raise ready until the following cycle.
    assign w_space          = (r_occupancy < c_DEPTH);
    assign w_owner_valid    = req_valid[r_grant_id];
    assign w_handshake      = (r_state == GRANT) && w_owner_valid && w_space && !reset;
    assign w_rd_dec         = fifo_rd_done && (r_occupancy != '0);
    assign w_rr_after_owner = (r_grant_id == c_LAST_ID) ? '0 : (r_grant_id + c_IDX_ONE);

    always_comb begin
        req_ready = '0;
        if ((r_state == GRANT) && w_space && !reset) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_id_nxt    = r_grant_id;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_fifo_wren_nxt   = w_handshake;
        w_fifo_wrdata_nxt = w_handshake ? w_lane[r_grant_id] : r_fifo_wrdata;

        // The slot is reserved at handshake, one cycle before the write lands.
        case ({w_handshake, w_rd_dec})
            2'b10:   w_occupancy_nxt = r_occupancy + c_OCC_ONE;
            2'b01:   w_occupancy_nxt = r_occupancy - c_OCC_ONE;
            default: w_occupancy_nxt = r_occupancy;
        endcase

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = GRANT;
                    w_grant_id_nxt = w_pick_id;
                    w_beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_owner_valid) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_rr_after_owner;
                end else if (w_handshake) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    if ((r_beat_cnt + 8'd1) == c_MAX_BURST) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_rr_after_owner;
                    end
                end
                // Valid owner with no space simply holds the grant.
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_occupancy   <= '0;
            r_fifo_wren   <= 1'b0;
            r_fifo_wrdata <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_occupancy   <= w_occupancy_nxt;
            r_fifo_wren   <= w_fifo_wren_nxt;
            r_fifo_wrdata <= w_fifo_wrdata_nxt;
        end
    end

    assign fifo_wren   = r_fifo_wren;
    assign fifo_wrdata = r_fifo_wrdata;
    assign occupancy   = r_occupancy;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == GRANT);

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=32,
//             DEPTH=16, MAX_BURST=4). Inputs change just after the falling
//             edge; outputs are compared 1 ns later, before the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_wren;
    logic [31:0]  fifo_wrdata;
    logic         fifo_rd_done;
    logic [4:0]   occupancy;
    logic [1:0]   grant_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (32),
        .DEPTH     (16),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wren    (fifo_wren),
        .fifo_wrdata  (fifo_wrdata),
        .fifo_rd_done (fifo_rd_done),
        .occupancy    (occupancy),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data0;
        logic        rd;
        logic [3:0]  ready;
        logic        wren;
        logic [31:0] wrdata;
        int          occ;
        logic        busy;
        int          gid;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] rdy, input logic wren,
                           input logic [31:0] wd, input logic chk_wd, input int occ,
                           input logic bsy, input int gid);
        chk($sformatf("%s.ready", tag), 64'(req_ready), 64'(rdy));
        chk($sformatf("%s.wren", tag), 64'(fifo_wren), 64'(wren));
        if (chk_wd) chk($sformatf("%s.wrdata", tag), 64'(fifo_wrdata), 64'(wd));
        chk($sformatf("%s.occ", tag), 64'(occupancy), 64'(occ));
        chk($sformatf("%s.busy", tag), 64'(busy), 64'(bsy));
        if (bsy) chk($sformatf("%s.gid", tag), 64'(grant_id), 64'(gid));
    endtask

    task automatic set_lane(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    // Waits for the falling edge, applies valid/read strobe, settles 1 ns.
    task automatic step(input logic [3:0] v, input logic rd);
        @(negedge clk);
        req_valid    = v;
        fifo_rd_done = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        req_valid    = '0;
        fifo_rd_done = 1'b0;
        req_data     = '0;
        @(negedge clk);
        #1;
        chk_all("reset", 4'b0000, 1'b0, 32'h0, 1'b1, 0, 1'b0, 0);
        chk("reset.gid0", 64'(grant_id), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        fifo_rd_done = 1'b0;

        // ---------------- single requester, 3 beats (table driven) ----------
        tbl[0] = '{4'b0001, 32'hA000_000A, 1'b0, 4'b0000, 1'b0, 32'h0,         0, 1'b0, 0};
        tbl[1] = '{4'b0001, 32'hA000_000A, 1'b0, 4'b0001, 1'b0, 32'h0,         0, 1'b1, 0};
        tbl[2] = '{4'b0001, 32'hB000_000B, 1'b0, 4'b0001, 1'b1, 32'hA000_000A, 1, 1'b1, 0};
        tbl[3] = '{4'b0001, 32'hC000_000C, 1'b0, 4'b0001, 1'b1, 32'hB000_000B, 2, 1'b1, 0};
        tbl[4] = '{4'b0000, 32'h0,         1'b0, 4'b0001, 1'b1, 32'hC000_000C, 3, 1'b1, 0};
        tbl[5] = '{4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 32'hC000_000C, 3, 1'b0, 0};

        do_reset();
        for (int r = 0; r < 6; r++) begin
            step(tbl[r].valid, tbl[r].rd);
            set_lane(0, tbl[r].data0);
            chk_all($sformatf("single[%0d]", r), tbl[r].ready, tbl[r].wren,
                    tbl[r].wrdata, 1'b1, tbl[r].occ, tbl[r].busy, tbl[r].gid);
        end

        // ---------------- all four valid, rotation and fill -----------------
        begin
            int          occ_m;
            logic        prev_hs;
            logic [31:0] prev_d;
            do_reset();
            occ_m   = 0;
            prev_hs = 1'b0;
            prev_d  = '0;
            for (int t = 0; t < 25; t++) begin
                int          p;
                logic        busy_e;
                int          gid_e;
                logic [3:0]  rdy_e;
                logic        hs;
                p = t % 5;
                step(4'b1111, 1'b0);
                for (int i = 0; i < 4; i++) set_lane(i, 32'((i << 8) | p));
                if (t < 20) begin
                    busy_e = (p != 0);
                    gid_e  = (p != 0) ? (t / 5) % 4 : ((t == 0) ? 0 : (t / 5 - 1) % 4);
                end else begin
                    busy_e = (t >= 21);
                    gid_e  = (t == 20) ? 3 : 0;
                end
                rdy_e = (busy_e && occ_m < 16) ? 4'(1 << gid_e) : 4'b0000;
                chk_all($sformatf("rot[%0d]", t), rdy_e, prev_hs, prev_d, prev_hs,
                        occ_m, busy_e, gid_e);
                hs      = busy_e && (occ_m < 16);
                prev_hs = hs;
                prev_d  = 32'((gid_e << 8) | p);
                if (hs) occ_m++;
            end
        end

        // ---------------- full boundary with requester 2 --------------------
        do_reset();
        for (int t = 0; t < 21; t++) begin
            step(4'b0100, 1'b0);
            set_lane(2, 32'h2000 + 32'(t));
        end
        step(4'b0100, 1'b1);
        chk_all("full.stall", 4'b0000, 1'b0, 32'h0, 1'b0, 16, 1'b1, 2);
        step(4'b0100, 1'b0);
        set_lane(2, 32'h0000_BEEF);
        chk_all("full.freed", 4'b0100, 1'b0, 32'h0, 1'b0, 15, 1'b1, 2);
        step(4'b0100, 1'b0);
        chk_all("full.refill", 4'b0000, 1'b1, 32'h0000_BEEF, 1'b1, 16, 1'b1, 2);

        // ---------------- simultaneous handshake and read at occ 5 ----------
        do_reset();
        for (int t = 0; t < 7; t++) begin
            step(4'b0001, 1'b0);
            set_lane(0, 32'(t));
        end
        step(4'b0001, 1'b1);
        set_lane(0, 32'h55);
        chk("simul.occ_before", 64'(occupancy), 64'd5);
        step(4'b0000, 1'b0);
        chk_all("simul.after", 4'b0001, 1'b1, 32'h55, 1'b1, 5, 1'b1, 0);
        step(4'b0000, 1'b0);
        chk("simul.idle_occ", 64'(occupancy), 64'd5);
        chk("simul.idle_busy", 64'(busy), 64'd0);

        // ---------------- read strobe at occupancy 0 ------------------------
        do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        chk("empty_rd.occ", 64'(occupancy), 64'd0);

        // ---------------- drop mid-burst, then reset mid-burst --------------
        do_reset();
        step(4'b1010, 1'b0);
        chk("drop.idle_busy", 64'(busy), 64'd0);
        step(4'b1010, 1'b0);
        chk_all("drop.g1", 4'b0010, 1'b0, 32'h0, 1'b0, 0, 1'b1, 1);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        chk_all("drop.fall", 4'b0010, 1'b1, 32'h0, 1'b0, 2, 1'b1, 1);
        step(4'b1000, 1'b0);
        chk("drop.bubble", 64'(busy), 64'd0);
        step(4'b1000, 1'b0);
        chk_all("drop.g3", 4'b1000, 1'b0, 32'h0, 1'b0, 2, 1'b1, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid.ready_gated", 64'(req_ready), 64'd0);
        chk("rst_mid.wren_pending", 64'(fifo_wren), 64'd1);
        @(negedge clk);
        #1;
        chk_all("rst_mid.after", 4'b0000, 1'b0, 32'h0, 1'b0, 0, 1'b0, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
